seg_display_scanner: RTL

- Time-multiplexes one shared binary_to_segment decoder across NUM_DIGITS common-anode 7-segment digits.
- Cycles through the digits, drives the decoder's 4-bit code and the active-low anode strobes, and inserts a blanking guard at the start of each digit slot to suppress ghosting.
- New display values are double-buffered and applied only at a frame boundary, so a frame never mixes old and new digits.
- Sits between game/score logic and the board's segment/anode pins.

---
 rtl/seg_display_scanner.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/seg_display_scanner.sv
// seg_display_scanner: scans NUM_DIGITS common-anode 7-segment digits through
// one shared binary_to_segment decoder. Each digit slot starts with a short
// all-anodes-off guard to hide ghosting. New digit values are double-buffered
// and only become visible at a frame boundary, so a frame never mixes old and
// new digits.
module seg_display_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [3:0]              bin_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    load_ack,
  output logic                    frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CntMax = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IdxMax = IW'(NUM_DIGITS - 1);

  // The scan sits idle for one cycle after reset so the first visible slot
  // cycle is the one after the first unreset edge.
  typedef enum logic {
    ST_START,
    ST_SCAN
  } state_t;

  state_t state;
  state_t state_next;
  logic   advance;

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] active;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic                    pending;
  logic                    wrap_flag;
  logic                    ack_flag;

  logic                    slot_end;
  logic                    frame_wrap;
  logic                    in_blank;
  logic [3:0]              cur_code;
  logic [NUM_DIGITS-1:0]   sel;

  // State register for the start-up sequencer.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_START;
    else     state <= state_next;
  end

  // Leave the start state after one cycle and keep scanning from then on.
  always_comb begin
    state_next = state;
    case (state)
      ST_START: state_next = ST_SCAN;
      default:  state_next = ST_SCAN;
    endcase
  end

  // Counters only move once the sequencer is scanning.
  always_comb begin
    advance = 1'b0;
    if (state == ST_SCAN) advance = 1'b1;
  end

  assign slot_end   = advance && (cnt == CntMax);
  assign frame_wrap = slot_end && (idx == IdxMax);

  generate
    if (BLANK_CYCLES == 0) begin : g_noblank
      assign in_blank = 1'b0;
    end else begin : g_blank
      localparam logic [CW-1:0] BlankLim = CW'(BLANK_CYCLES);
      assign in_blank = (cnt < BlankLim);
    end
  endgenerate

  // Pick the code and one-hot anode position for the digit being scanned.
  always_comb begin
    cur_code = active[{idx, 2'b00} +: 4];
    sel      = NUM_DIGITS'(1) << idx;
  end

  // Slot counter and digit index; the index steps when a slot ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (advance) begin
      if (cnt == CntMax) begin
        cnt <= '0;
        idx <= (idx == IdxMax) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Double buffer: loads land in shadow and move to active only at the frame
  // wrap; a load in the wrap cycle itself goes straight to active.
  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else begin
      if (load) shadow <= digits_in;
      if (frame_wrap) begin
        if (load)         active <= digits_in;
        else if (pending) active <= shadow;
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Remember a frame wrap so its pulses line up with digit 0's first cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_flag <= 1'b0;
      ack_flag  <= 1'b0;
    end else begin
      wrap_flag <= frame_wrap;
      ack_flag  <= frame_wrap && (pending || load);
    end
  end

  // Registered pin drivers: code, active-low anodes and the two pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_out    <= 4'd0;
      an         <= '1;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap_flag;
      load_ack   <= ack_flag;
      if (advance) begin
        bin_out <= digit_en[idx] ? cur_code : 4'd0;
        an      <= (digit_en[idx] && !in_blank) ? ~sel : '1;
      end else begin
        bin_out <= 4'd0;
        an      <= '1;
      end
    end
  end

endmodule
